// File: rtl/aes_ctrl_pkg.sv
// rtl/aes_ctrl_pkg.sv - shared types, phase table and known-answer vectors for the AES self-test sequencer
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam int NUM_PHASES = 6;

    localparam logic [2:0] PH_C128  = 3'd0;
    localparam logic [2:0] PH_IC128 = 3'd1;
    localparam logic [2:0] PH_C192  = 3'd2;
    localparam logic [2:0] PH_IC192 = 3'd3;
    localparam logic [2:0] PH_C256  = 3'd4;
    localparam logic [2:0] PH_IC256 = 3'd5;

    // Round count per phase, 4 bits per entry, phase 0 in the low nibble.
    localparam logic [23:0] NR_OF_PHASE = {4'd14, 4'd14, 4'd12, 4'd12, 4'd10, 4'd10};

    localparam logic [127:0] DEF_PLAIN_TEXT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] DEF_EXP_CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] DEF_EXP_CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] DEF_EXP_CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    function automatic logic [3:0] nrOf(input logic [2:0] ph);
        logic [3:0] r;
        r = NR_OF_PHASE[3:0];
        for (int p = 0; p < NUM_PHASES; p++) begin
            if (ph == 3'(p)) r = NR_OF_PHASE[4*p +: 4];
        end
        return r;
    endfunction

    // Returns {found, index} of the lowest enabled phase at or above 'from'.
    function automatic logic [3:0] nextEnabled(input logic [5:0] en, input logic [3:0] from);
        logic [3:0] r;
        r = 4'b0;
        for (int p = NUM_PHASES - 1; p >= 0; p--) begin
            if (en[p] && (4'(p) >= from)) r = {1'b1, 3'(p)};
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_result_check.sv
// rtl/aes_result_check.sv - selects the active core's state and compares it with its known answer
module aes_result_check
    import aes_ctrl_pkg::*;
#(
    parameter logic [127:0] PLAIN_TEXT = DEF_PLAIN_TEXT,
    parameter logic [127:0] EXP_CT128  = DEF_EXP_CT128,
    parameter logic [127:0] EXP_CT192  = DEF_EXP_CT192,
    parameter logic [127:0] EXP_CT256  = DEF_EXP_CT256
) (
    input  logic [767:0] coreOut,
    input  logic [2:0]   phase,
    output logic [127:0] slice,
    output logic         match
);

    logic [127:0] expected;

    // Inverse-cipher phases must recover the plaintext, so they share the default.
    always_comb begin
        slice    = '0;
        expected = PLAIN_TEXT;
        case (phase)
            PH_C128:  begin slice = coreOut[0   +: 128]; expected = EXP_CT128; end
            PH_IC128: begin slice = coreOut[128 +: 128]; end
            PH_C192:  begin slice = coreOut[256 +: 128]; expected = EXP_CT192; end
            PH_IC192: begin slice = coreOut[384 +: 128]; end
            PH_C256:  begin slice = coreOut[512 +: 128]; expected = EXP_CT256; end
            PH_IC256: begin slice = coreOut[640 +: 128]; end
            default:  ;
        endcase
    end

    assign match = (slice == expected);

endmodule

// File: rtl/aes_selftest_sequencer.sv
// rtl/aes_selftest_sequencer.sv - walks the six AES cores through a known-answer sweep and records results
module aes_selftest_sequencer
    import aes_ctrl_pkg::*;
#(
    parameter logic [127:0] PLAIN_TEXT = DEF_PLAIN_TEXT,
    parameter logic [127:0] EXP_CT128  = DEF_EXP_CT128,
    parameter logic [127:0] EXP_CT192  = DEF_EXP_CT192,
    parameter logic [127:0] EXP_CT256  = DEF_EXP_CT256,
    parameter logic [5:0]   PHASE_EN   = 6'b111111,
    parameter int           RUN_SLACK  = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         continuous,
    input  logic [767:0] core_out,
    output logic [5:0]   core_en,
    output logic         core_rst,
    output logic [127:0] display_out,
    output logic [3:0]   round_num,
    output logic [2:0]   phase,
    output logic         busy,
    output logic [5:0]   pass_vec,
    output logic         done,
    output logic         success_flag
);

    state_t       state, stateNext;
    logic [2:0]   phaseReg, phaseNext;
    logic [7:0]   runCnt, runCntInc;
    logic [3:0]   roundReg, roundNext, nr;
    logic [5:0]   passReg;
    logic         successReg;
    logic [127:0] displayReg, slice;
    logic         match, runLast, loadPass, checkWrite;
    logic [3:0]   firstPh, followingPh;

    aes_result_check #(
        .PLAIN_TEXT(PLAIN_TEXT),
        .EXP_CT128 (EXP_CT128),
        .EXP_CT192 (EXP_CT192),
        .EXP_CT256 (EXP_CT256)
    ) u_check (
        .coreOut(core_out),
        .phase  (phaseReg),
        .slice  (slice),
        .match  (match)
    );

    assign nr          = nrOf(phaseReg);
    assign runCntInc   = runCnt + 8'd1;
    assign runLast     = (runCnt == 8'(nr) + 8'(RUN_SLACK));
    assign firstPh     = nextEnabled(PHASE_EN, 4'd0);
    assign followingPh = nextEnabled(PHASE_EN, {1'b0, phaseReg} + 4'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            phaseReg   <= '0;
            runCnt     <= '0;
            roundReg   <= '0;
            passReg    <= '0;
            successReg <= 1'b0;
            displayReg <= PLAIN_TEXT;
        end else begin
            state    <= stateNext;
            phaseReg <= phaseNext;
            runCnt   <= (state == ST_RUN) ? runCntInc : '0;
            roundReg <= (stateNext == ST_RUN) ? roundNext : '0;
            if (loadPass) begin
                passReg <= ~PHASE_EN;
            end else if (checkWrite) begin
                passReg[phaseReg] <= match;
            end
            if (state == ST_DONE) successReg <= &passReg;
            displayReg <= (state == ST_IDLE) ? PLAIN_TEXT : slice;
        end
    end

    always_comb begin
        stateNext  = state;
        phaseNext  = phaseReg;
        loadPass   = 1'b0;
        checkWrite = 1'b0;
        roundNext  = '0;
        core_en    = '0;
        core_rst   = 1'b0;
        busy       = (state != ST_IDLE);
        done       = 1'b0;
        // Round index for the next RUN cycle, held at Nr through the slack cycles.
        if (state == ST_RUN) begin
            roundNext = (runCntInc >= {4'b0, nr}) ? nr : runCntInc[3:0];
        end
        case (state)
            ST_IDLE: begin
                if (start) begin
                    loadPass  = 1'b1;
                    phaseNext = firstPh[2:0];
                    stateNext = firstPh[3] ? ST_LOAD : ST_DONE;
                end
            end
            ST_LOAD: begin
                core_rst  = 1'b1;
                core_en   = 6'b000001 << phaseReg;
                stateNext = ST_RUN;
            end
            ST_RUN: begin
                core_en = 6'b000001 << phaseReg;
                if (runLast) stateNext = ST_CHECK;
            end
            ST_CHECK: begin
                core_en    = 6'b000001 << phaseReg;
                checkWrite = 1'b1;
                if (followingPh[3]) begin
                    phaseNext = followingPh[2:0];
                    stateNext = ST_LOAD;
                end else begin
                    stateNext = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (continuous) begin
                    loadPass  = 1'b1;
                    phaseNext = firstPh[2:0];
                    stateNext = firstPh[3] ? ST_LOAD : ST_DONE;
                end else begin
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    assign display_out  = displayReg;
    assign round_num    = roundReg;
    assign phase        = phaseReg;
    assign pass_vec     = passReg;
    assign success_flag = successReg;

endmodule

// File: tb/tb_aes_selftest_sequencer.sv
// tb/tb_aes_selftest_sequencer.sv - scoreboard bench for the AES self-test sequencer over four configurations
module tb_aes_selftest_sequencer;

    localparam int NI = 4;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [23:0] EN_ALL    = {6'b110101, 6'b000000, 6'b000011, 6'b111111};
    localparam logic [31:0] SLACK_ALL = {8'd2, 8'd0, 8'd0, 8'd0};

    typedef struct {
        logic [5:0]   en;
        logic         rst;
        logic [3:0]   rn;
        logic [2:0]   ph;
        bit           chkPh;
        bit           dn;
        logic [5:0]   pv;
        bit           chkDisp;
        logic [127:0] disp;
    } item_t;

    logic clk = 1'b0;
    logic dutReset [NI];
    logic start [NI];
    logic cont [NI];
    logic [767:0] coreOut [NI];
    logic [5:0] coreEn [NI];
    logic coreRst [NI];
    logic [127:0] disp [NI];
    logic [3:0] roundNum [NI];
    logic [2:0] phase [NI];
    logic busy [NI];
    logic [5:0] passVec [NI];
    logic done [NI];
    logic succ [NI];

    item_t sbq [NI][$];
    logic [5:0] idlePass [NI];
    logic idleSucc [NI];
    bit succPend [NI];
    logic succExp [NI];
    int vectors = 0;
    int miscompares = 0;
    bit monOn = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gDut
        aes_selftest_sequencer #(
            .PHASE_EN (EN_ALL[6*g +: 6]),
            .RUN_SLACK(int'(SLACK_ALL[8*g +: 8]))
        ) dut (
            .clk         (clk),
            .reset       (dutReset[g]),
            .start       (start[g]),
            .continuous  (cont[g]),
            .core_out    (coreOut[g]),
            .core_en     (coreEn[g]),
            .core_rst    (coreRst[g]),
            .display_out (disp[g]),
            .round_num   (roundNum[g]),
            .phase       (phase[g]),
            .busy        (busy[g]),
            .pass_vec    (passVec[g]),
            .done        (done[g]),
            .success_flag(succ[g])
        );
    end

    function automatic logic [5:0] enOf(input int i);
        return EN_ALL[6*i +: 6];
    endfunction

    function automatic int slackOf(input int i);
        return int'(SLACK_ALL[8*i +: 8]);
    endfunction

    function automatic logic [127:0] goodSlice(input int p);
        if (p % 2 == 1) return PT;
        if (p == 0) return CT128;
        if (p == 2) return CT192;
        return CT256;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setCores(input int i, input logic [5:0] mask, input bit zero);
        logic [127:0] s;
        for (int p = 0; p < 6; p++) begin
            s = goodSlice(p);
            if (mask[p]) s = zero ? 128'h0 : (s ^ {$urandom, $urandom, $urandom, $urandom | 32'h1});
            coreOut[i][128*p +: 128] = s;
        end
    endtask

    // Expected cycle-by-cycle trace of one sweep: per enabled phase one load cycle,
    // Nr+1+slack run cycles and one check cycle, then a single done cycle.
    task automatic pushSweep(input int i, output int len);
        item_t it;
        logic [5:0] en;
        logic [5:0] pv;
        int nr;
        int sl;
        en = enOf(i);
        sl = slackOf(i);
        len = 0;
        for (int p = 0; p < 6; p++) begin
            pv[p] = !en[p] || (coreOut[i][128*p +: 128] == goodSlice(p));
            if (en[p]) begin
                nr = 10 + 2 * (p / 2);
                it = '{default: '0};
                it.en = 6'b000001 << p;
                it.ph = 3'(p);
                it.chkPh = 1'b1;
                it.rst = 1'b1;
                sbq[i].push_back(it);
                len++;
                it.rst = 1'b0;
                for (int k = 0; k <= nr + sl; k++) begin
                    it.rn = 4'((k < nr) ? k : nr);
                    sbq[i].push_back(it);
                    len++;
                end
                it.rn = 4'd0;
                it.chkDisp = 1'b1;
                it.disp = coreOut[i][128*p +: 128];
                sbq[i].push_back(it);
                len++;
            end
        end
        it = '{default: '0};
        it.dn = 1'b1;
        it.pv = pv;
        sbq[i].push_back(it);
        len++;
    endtask

    task automatic runSweeps(input int i, input int nsw, input bit randStart, input int abortAt);
        int len;
        int total;
        start[i] = 1'b1;
        cont[i] = (nsw > 1);
        tick();
        start[i] = 1'b0;
        total = 0;
        len = 0;
        for (int s = 0; s < nsw; s++) begin
            pushSweep(i, len);
            total += len;
        end
        for (int c = 1; c <= total; c++) begin
            if (c == abortAt) begin
                dutReset[i] = 1'b1;
                tick();
                dutReset[i] = 1'b0;
                cont[i] = 1'b0;
                start[i] = 1'b0;
                sbq[i].delete();
                idlePass[i] = '0;
                idleSucc[i] = 1'b0;
                succPend[i] = 1'b0;
                return;
            end
            if (c > total - len) cont[i] = 1'b0;
            start[i] = randStart && ($urandom_range(3) == 0);
            tick();
        end
        start[i] = 1'b0;
        cont[i] = 1'b0;
        repeat (2) tick();
    endtask

    always @(negedge clk) begin
        item_t it;
        bit ok;
        if (monOn) begin
            for (int i = 0; i < NI; i++) begin
                if (succPend[i]) begin
                    succPend[i] = 1'b0;
                    idleSucc[i] = succExp[i];
                    vectors++;
                    if (succ[i] !== succExp[i]) begin
                        miscompares++;
                        $display("FAIL success_flag dut%0d @%0t: got %b expected %b", i, $time, succ[i], succExp[i]);
                    end
                end
                if (sbq[i].size() > 0) begin
                    it = sbq[i].pop_front();
                    ok = (busy[i] === 1'b1) && (coreEn[i] === it.en) && (coreRst[i] === it.rst) &&
                         (roundNum[i] === it.rn) && (done[i] === it.dn);
                    if (it.chkPh && (phase[i] !== it.ph)) ok = 1'b0;
                    if (it.dn && (passVec[i] !== it.pv)) ok = 1'b0;
                    if (it.chkDisp && (disp[i] !== it.disp)) ok = 1'b0;
                    vectors++;
                    if (!ok) begin
                        miscompares++;
                        $display("FAIL sweep dut%0d @%0t: got busy=%b en=%h rst=%b rn=%0d ph=%0d done=%b pv=%h disp=%h, expected en=%h rst=%b rn=%0d ph=%0d done=%b pv=%h disp=%h",
                                 i, $time, busy[i], coreEn[i], coreRst[i], roundNum[i], phase[i], done[i], passVec[i], disp[i],
                                 it.en, it.rst, it.rn, it.ph, it.dn, it.pv, it.disp);
                    end
                    if (it.dn) begin
                        succPend[i] = 1'b1;
                        succExp[i] = &it.pv;
                        idlePass[i] = it.pv;
                    end
                end else begin
                    ok = (busy[i] === 1'b0) && (coreEn[i] === 6'h0) && (coreRst[i] === 1'b0) &&
                         (roundNum[i] === 4'h0) && (done[i] === 1'b0) &&
                         (passVec[i] === idlePass[i]) && (succ[i] === idleSucc[i]);
                    vectors++;
                    if (!ok) begin
                        miscompares++;
                        $display("FAIL idle dut%0d @%0t: got busy=%b en=%h rst=%b rn=%0d done=%b pv=%h succ=%b, expected busy=0 en=00 rst=0 rn=0 done=0 pv=%h succ=%b",
                                 i, $time, busy[i], coreEn[i], coreRst[i], roundNum[i], done[i], passVec[i], succ[i],
                                 idlePass[i], idleSucc[i]);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            dutReset[i] = 1'b1;
            start[i] = 1'b0;
            cont[i] = 1'b0;
            setCores(i, 6'h0, 1'b0);
            idlePass[i] = '0;
            idleSucc[i] = 1'b0;
            succPend[i] = 1'b0;
            succExp[i] = 1'b0;
        end
        repeat (3) tick();
        for (int i = 0; i < NI; i++) dutReset[i] = 1'b0;
        monOn = 1'b1;
        for (int i = 0; i < NI; i++) begin
            vectors++;
            if (disp[i] !== PT) begin
                miscompares++;
                $display("FAIL reset display dut%0d: got %h expected %h", i, disp[i], PT);
            end
        end

        runSweeps(0, 1, 1'b0, 0);
        setCores(0, 6'b000100, 1'b1);
        runSweeps(0, 1, 1'b0, 0);
        repeat (3) begin
            setCores(0, 6'($urandom), 1'b0);
            runSweeps(0, 1, 1'b1, 0);
        end
        setCores(0, 6'h0, 1'b0);
        runSweeps(0, 3, 1'b1, 0);
        runSweeps(0, 1, 1'b0, 47);
        runSweeps(0, 1, 1'b0, 0);

        for (int i = 1; i < NI; i++) begin
            setCores(i, 6'h0, 1'b0);
            runSweeps(i, 1, 1'b1, 0);
            setCores(i, 6'($urandom), 1'b0);
            runSweeps(i, (i == 2) ? 1 : 2, 1'b1, 0);
        end

        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
